// File: rtl/md_sequencer_pkg.sv
// Shared CPU definitions for the multiply/divide sequencer: operation codes,
// FSM state encoding and small op-classification helpers.
package md_sequencer_pkg;

  localparam int MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // Long operations are the ones that occupy the unit for several cycles.
  function automatic logic is_long_op(logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// Issue/result bundle between the E stage, hazard unit and the multiply/divide
// sequencer, plus the sequencer's FSM state for observation.
interface md_sequencer_if;
  import md_sequencer_pkg::*;

  // start is a single-cycle issue strobe with no ready: it is accepted only
  // while the sequencer is IDLE; busy and md_stall are the only backpressure.
  logic                start;
  logic [MD_OP_W-1:0]  md_op;
  logic [31:0]         src_a;
  logic [31:0]         src_b;
  logic                d_is_md;
  logic                busy;
  logic [31:0]         hi;
  logic [31:0]         lo;
  logic                md_stall;
  md_state_e           state;

  modport master (
    output start, md_op, src_a, src_b, d_is_md,
    input  busy, hi, lo, md_stall, state
  );

  modport slave (
    input  start, md_op, src_a, src_b, d_is_md,
    output busy, hi, lo, md_stall, state
  );

endinterface

// File: rtl/md_core.sv
// Combinational 64-bit multiply/divide datapath. Division results are packed
// as {remainder, quotient}; a zero divisor is flagged and the result is don't-care.
module md_core
  import md_sequencer_pkg::*;
(
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [31:0]        src_a,
  input  logic [31:0]        src_b,
  output logic [63:0]        result,
  output logic               div_by_zero
);

  logic signed [63:0] a_s64, b_s64;
  logic        [63:0] a_u64, b_u64;
  logic        [31:0] b_safe;
  logic signed [32:0] a_s33, b_s33, q_s33, r_s33;
  logic        [31:0] q_u, r_u;
  logic               core_unused;

  always_comb begin
    a_s64       = {{32{src_a[31]}}, src_a};
    b_s64       = {{32{src_b[31]}}, src_b};
    a_u64       = {32'd0, src_a};
    b_u64       = {32'd0, src_b};
    div_by_zero = (src_b == 32'd0);
    // Substitute a divisor of 1 so a zero divisor never produces X.
    b_safe      = div_by_zero ? 32'd1 : src_b;
    // 33-bit signed division keeps -2^31 / -1 from overflowing.
    a_s33       = {src_a[31], src_a};
    b_s33       = {b_safe[31], b_safe};
    q_s33       = a_s33 / b_s33;
    r_s33       = a_s33 % b_s33;
    q_u         = src_a / b_safe;
    r_u         = src_a % b_safe;
    core_unused = q_s33[32] ^ r_s33[32];

    result = '0;
    case (md_op)
      MD_MULT:  result = a_s64 * b_s64;
      MD_MULTU: result = a_u64 * b_u64;
      MD_DIV:   result = {r_s33[31:0], q_s33[31:0]};
      MD_DIVU:  result = {r_u, q_u};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer: latches a result at issue, holds the
// unit busy for a fixed cycle count, then commits it to the HI/LO registers.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           reset,
  md_sequencer_if.slave  md_if
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        pending_q, pending_d;
  logic               pend_wr_q, pend_wr_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic [63:0]        core_result;
  logic               core_dbz;
  logic               idle_start;
  logic               busy;

  md_core u_core (
    .md_op       (md_if.md_op),
    .src_a       (md_if.src_a),
    .src_b       (md_if.src_b),
    .result      (core_result),
    .div_by_zero (core_dbz)
  );

  assign idle_start = (state_q == ST_IDLE) && md_if.start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      pending_q <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (idle_start && is_long_op(md_if.md_op)) state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (state_q == ST_BUSY) begin
      cnt_d = cnt_q - CNT_W'(1);
      // A divide by zero runs the full sequence but never commits.
      if ((cnt_q == CNT_W'(1)) && pend_wr_q) begin
        hi_d = pending_q[63:32];
        lo_d = pending_q[31:0];
      end
    end else if (idle_start) begin
      if (is_long_op(md_if.md_op)) begin
        pending_d = core_result;
        pend_wr_d = !(is_div_op(md_if.md_op) && core_dbz);
        cnt_d     = is_div_op(md_if.md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (md_if.md_op == MD_MTHI) begin
        hi_d = md_if.src_a;
      end else if (md_if.md_op == MD_MTLO) begin
        lo_d = md_if.src_a;
      end
    end
  end

  always_comb begin
    busy           = (state_q == ST_BUSY);
    md_if.busy     = busy;
    md_if.hi       = hi_q;
    md_if.lo       = lo_q;
    md_if.state    = state_q;
    md_if.md_stall = md_if.d_is_md && (busy || (md_if.start && is_long_op(md_if.md_op)));
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed corner cases followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_md_sequencer;
  import md_sequencer_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_sequencer_if md_if ();

  md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .md_if (md_if)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int busy_seen;
  int stall_seen;

  // Behavioural model: remaining busy cycles, architectural HI/LO, and the
  // queue of results waiting to be committed.
  int          m_rem;
  logic [31:0] m_hi, m_lo;
  logic        m_commit;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_long(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  // Reference arithmetic in 64-bit integers; division by zero is excluded by the caller.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, q, r, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = 0;
    case (op)
      3'd1: p = sa * sb;
      3'd2: p = ua * ub;
      3'd3: begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
      3'd4: begin q = ua / ub; r = ua % ub; p = {r[31:0], q[31:0]}; end
      default: p = 0;
    endcase
    return p;
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model at the edge.
  task automatic step(input logic st, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic dm, input logic rs);
    logic        exp_busy, exp_stall;
    logic [63:0] res;
    md_if.start   = st;
    md_if.md_op   = op;
    md_if.src_a   = a;
    md_if.src_b   = b;
    md_if.d_is_md = dm;
    reset         = rs;
    #1;
    exp_busy  = (m_rem > 0);
    exp_stall = dm && (exp_busy || (st && is_long(op)));
    check("busy", 64'(md_if.busy), 64'(exp_busy));
    check("md_stall", 64'(md_if.md_stall), 64'(exp_stall));
    check("hi", 64'(md_if.hi), 64'(m_hi));
    check("lo", 64'(md_if.lo), 64'(m_lo));
    check("state", 64'(md_if.state), exp_busy ? 64'(ST_BUSY) : 64'(ST_IDLE));
    busy_seen  += int'(md_if.busy);
    stall_seen += int'(md_if.md_stall);
    @(posedge clk);
    if (rs) begin
      m_rem = 0; m_hi = '0; m_lo = '0; exp_q.delete();
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        res = exp_q.pop_front();
        if (m_commit) begin m_hi = res[63:32]; m_lo = res[31:0]; end
      end
    end else if (st) begin
      if (is_long(op)) begin
        m_commit = !((op == 3'd3 || op == 3'd4) && b == 32'd0);
        exp_q.push_back(m_commit ? ref_md(op, a, b) : 64'd0);
        m_rem = (op == 3'd3 || op == 3'd4) ? DIV_N : MULT_N;
      end else if (op == 3'd5) begin
        m_hi = a;
      end else if (op == 3'd6) begin
        m_lo = a;
      end
    end
    #2;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic dm);
    step(1'b1, op, a, b, dm, 1'b0);
  endtask

  task automatic idle(input logic dm);
    step(1'b0, 3'd0, 32'd0, 32'd0, dm, 1'b0);
  endtask

  // Model busy is at most DIV_N cycles, so this loop is bounded.
  task automatic drain(input logic dm);
    while (m_rem > 0) idle(dm);
  endtask

  initial begin
    md_if.start = 1'b0; md_if.md_op = '0; md_if.src_a = '0; md_if.src_b = '0; md_if.d_is_md = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    m_rem = 0; m_hi = '0; m_lo = '0; m_commit = 1'b0;
    check("reset_busy", 64'(md_if.busy), 64'd0);
    check("reset_hi", 64'(md_if.hi), 64'd0);
    check("reset_lo", 64'(md_if.lo), 64'd0);

    busy_seen = 0; stall_seen = 0;
    issue(MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b1);
    drain(1'b1);
    check("mult_busy_cycles", 64'(busy_seen), 64'd5);
    check("mult_stall_cycles", 64'(stall_seen), 64'd6);
    check("mult_hi", 64'(md_if.hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(md_if.lo), 64'hFFFF_FFFE);

    busy_seen = 0; stall_seen = 0;
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    drain(1'b0);
    check("multu_stall_cycles", 64'(stall_seen), 64'd0);
    check("multu_hi", 64'(md_if.hi), 64'h1);
    check("multu_lo", 64'(md_if.lo), 64'hFFFF_FFFE);

    busy_seen = 0;
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    drain(1'b0);
    check("div_busy_cycles", 64'(busy_seen), 64'd10);
    check("div_lo", 64'(md_if.lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(md_if.hi), 64'hFFFF_FFFF);

    issue(MD_DIVU, 32'd7, 32'd2, 1'b0);
    drain(1'b0);
    check("divu_lo", 64'(md_if.lo), 64'd3);
    check("divu_hi", 64'(md_if.hi), 64'd1);

    issue(MD_MTHI, 32'h11, 32'd0, 1'b0);
    issue(MD_MTLO, 32'h22, 32'd0, 1'b0);
    busy_seen = 0;
    issue(MD_DIVU, 32'd5, 32'd0, 1'b0);
    drain(1'b0);
    check("dbz_busy_cycles", 64'(busy_seen), 64'd10);
    check("dbz_hi", 64'(md_if.hi), 64'h11);
    check("dbz_lo", 64'(md_if.lo), 64'h22);

    busy_seen = 0;
    issue(MD_MTHI, 32'hABCD, 32'd0, 1'b0);
    check("mthi_hi", 64'(md_if.hi), 64'hABCD);
    check("mthi_busy", 64'(md_if.busy) + 64'(busy_seen), 64'd0);

    issue(MD_MULT, 32'd3, 32'd4, 1'b0);
    idle(1'b0);
    step(1'b1, MD_MTLO, 32'h5555, 32'd0, 1'b0, 1'b0);
    drain(1'b0);
    check("mtlo_in_busy_lo", 64'(md_if.lo), 64'd12);
    check("mtlo_in_busy_hi", 64'(md_if.hi), 64'd0);

    issue(MD_DIV, 32'd100, 32'd7, 1'b0);
    idle(1'b0);
    idle(1'b0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    check("abort_busy", 64'(md_if.busy), 64'd0);
    check("abort_hi", 64'(md_if.hi), 64'd0);
    check("abort_lo", 64'(md_if.lo), 64'd0);
    repeat (12) idle(1'b0);
    check("abort_no_write", {md_if.hi, md_if.lo}, 64'd0);

    step(1'b1, MD_MULT, 32'd9, 32'd9, 1'b0, 1'b1);
    check("reset_over_start", 64'(md_if.busy), 64'd0);

    for (int i = 0; i < 400; i++) begin
      logic        st, dm, rs;
      logic [2:0]  op;
      logic [31:0] a, b;
      st = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        2:       a = 32'($urandom_range(0, 20));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      dm = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 99) == 0);
      step(st, op, a, b, dm, rs);
    end
    drain(1'b0);
    idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
